mdu: RTL and testbench



---
 rtl/mdu.sv | 157 +++++++++++++++
 tb/tb_mdu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// HI/LO multiply/divide unit for the E stage.
// Fixed-latency mult/div with a registered busy flag; mthi/mtlo in one cycle.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_we_q, pend_we_d;

    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic op_long;

    always_comb begin
        op_mult  = (mdu_op == 3'd1);
        op_multu = (mdu_op == 3'd2);
        op_div   = (mdu_op == 3'd3);
        op_divu  = (mdu_op == 3'd4);
        op_mthi  = (mdu_op == 3'd5);
        op_mtlo  = (mdu_op == 3'd6);
        op_long  = op_mult | op_multu | op_div | op_divu;
    end

    logic [63:0] prod_s, prod_u;
    logic        rs_neg, rt_neg, den_zero;
    logic [31:0] rs_mag, rt_mag, den_s, den_u;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod_s   = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
        rs_neg   = rs_data[31];
        rt_neg   = rt_data[31];
        rs_mag   = rs_neg ? (32'd0 - rs_data) : rs_data;
        rt_mag   = rt_neg ? (32'd0 - rt_data) : rt_data;
        den_zero = (rt_data == 32'd0);
        den_s    = den_zero ? 32'd1 : rt_mag;
        den_u    = den_zero ? 32'd1 : rt_data;
        q_mag    = rs_mag / den_s;
        r_mag    = rs_mag % den_s;
        q_s      = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
        r_s      = rs_neg ? (32'd0 - r_mag) : r_mag;
        q_u      = rs_data / den_u;
        r_u      = rs_data % den_u;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        unique case (state_q)
            IDLE: begin
                if (start && op_long) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    cnt_d     = (op_mult | op_multu) ? MULT_CNT : DIV_CNT;
                    pend_we_d = 1'b1;
                    if (op_mult) begin
                        pend_hi_d = prod_s[63:32];
                        pend_lo_d = prod_s[31:0];
                    end else if (op_multu) begin
                        pend_hi_d = prod_u[63:32];
                        pend_lo_d = prod_u[31:0];
                    end else if (op_div) begin
                        pend_hi_d = r_s;
                        pend_lo_d = q_s;
                        pend_we_d = !den_zero;
                    end else begin
                        pend_hi_d = r_u;
                        pend_lo_d = q_u;
                        pend_we_d = !den_zero;
                    end
                end else if (start && op_mthi) begin
                    hi_d = rs_data;
                end else if (start && op_mtlo) begin
                    lo_d = rs_data;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    pend_we_d = 1'b0;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (reset) begin
            state_d   = IDLE;
            cnt_d     = '0;
            busy_d    = 1'b0;
            hi_d      = 32'd0;
            lo_d      = 32'd0;
            pend_hi_d = 32'd0;
            pend_lo_d = 32'd0;
            pend_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        busy_q    <= busy_d;
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        pend_hi_q <= pend_hi_d;
        pend_lo_q <= pend_lo_d;
        pend_we_q <= pend_we_d;
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, arithmetic, mthi/mtlo, div-by-zero, reset abort.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        mdu_op  = op;
        rs_data = a;
        rt_data = b;
        step();
        start   = 1'b0;
        mdu_op  = 3'd0;
        rs_data = 32'hDEAD_BEEF;
        rt_data = 32'h0BAD_F00D;
    endtask

    // Issue a long op, expect busy for exactly n cycles with HI/LO frozen, then the result.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        for (int i = 0; i < n; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " hi held"}, hi, old_hi);
            chk({tag, " lo held"}, lo, old_lo);
            step();
        end
        chk({tag, " busy done"}, {31'd0, busy}, 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mdu_op  = 3'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        step();
        step();
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);

        start   = 1'b1;
        mdu_op  = 3'd5;
        rs_data = 32'h1234_5678;
        step();
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi lo", lo, 32'h7FFF_FFFC);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        mdu_op  = 3'd6;
        rs_data = 32'h9ABC_DEF0;
        step();
        start = 1'b0;
        chk("mtlo lo", lo, 32'h9ABC_DEF0);
        chk("mtlo hi", hi, 32'h1234_5678);
        chk("mtlo busy", {31'd0, busy}, 32'd0);

        issue(3'd0, 32'h5555_5555, 32'd1);
        chk("op0 busy", {31'd0, busy}, 32'd0);
        chk("op0 hi", hi, 32'h1234_5678);
        issue(3'd7, 32'h5555_5555, 32'd1);
        chk("op7 busy", {31'd0, busy}, 32'd0);
        chk("op7 lo", lo, 32'h9ABC_DEF0);

        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        chk("preset hi", hi, 32'h11);
        chk("preset lo", lo, 32'h22);
        run_op("div0", 3'd3, 32'd5, 32'd0, 10,
               32'h11, 32'h22, 32'h11, 32'h22);
        run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'h11, 32'h22, 32'h0, 32'h8000_0000);

        issue(3'd5, 32'hAAAA_0001, 32'd0);
        issue(3'd6, 32'hBBBB_0002, 32'd0);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("abort busy", {31'd0, busy}, 32'd1);
            step();
        end
        chk("abort busy4", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy off", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("abort no commit hi", hi, 32'd0);
        chk("abort no commit lo", lo, 32'd0);
        chk("abort idle", {31'd0, busy}, 32'd0);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk("ign busy", {31'd0, busy}, 32'd1);
            chk("ign hi held", hi, 32'd0);
            if (i == 2) begin
                start   = 1'b1;
                mdu_op  = 3'd3;
                rs_data = 32'd100;
                rt_data = 32'd3;
            end else if (i == 3) begin
                start  = 1'b1;
                mdu_op = 3'd5;
            end else begin
                start  = 1'b0;
                mdu_op = 3'd0;
            end
            step();
        end
        start  = 1'b0;
        mdu_op = 3'd0;
        chk("ign busy done", {31'd0, busy}, 32'd0);
        chk("ign hi", hi, 32'hFFFF_FFFF);
        chk("ign lo", lo, 32'hFFFF_FFFD);
        step();
        chk("ign stays idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
